// File: rtl/cv3_feeder_pkg.sv
// Shared types and constants for the 3-wide convolution column feeder.
// Build option: define CV3_FEEDER_ZERO_PAD_EN to add horizontal zero-pad columns.
package cv3_feeder_pkg;

  localparam int DATA_WIDTH           = 16;
  localparam int KERNEL_SIZE          = 3;
  localparam int INPUT_COL_SIZE       = 12;
  localparam int INPUT_CHANNEL_NUMBER = 4;
  localparam int NUM_COLS             = 12;

  localparam int CH_W   = $clog2(INPUT_CHANNEL_NUMBER);
  localparam int COL_W  = $clog2(NUM_COLS);
  localparam int KIDX_W = $clog2(KERNEL_SIZE);

  localparam int FM_COL_BITS = DATA_WIDTH * INPUT_COL_SIZE;
  localparam int K_COL_BITS  = DATA_WIDTH * KERNEL_SIZE;

`ifdef CV3_FEEDER_ZERO_PAD_EN
  localparam int PAD = (KERNEL_SIZE - 1) / 2;
`else
  localparam int PAD = 0;
`endif

  // Total columns streamed per sequence, pad columns included.
  localparam int N_STREAM = NUM_COLS + 2 * PAD;
  localparam int CNT_W    = $clog2(N_STREAM + 1);

  typedef logic [DATA_WIDTH-1:0] word_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_K,
    S_GAP,
    S_STREAM,
    S_FINISH
  } state_e;

endpackage

// File: rtl/cv3_col_buffer.sv
// Per-channel storage: feature-map columns and kernel columns, one write
// port each and combinational read by index. Contents are not reset.
module cv3_col_buffer
  import cv3_feeder_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   fm_we_i,
  input  logic [COL_W-1:0]       fm_col_i,
  input  logic [FM_COL_BITS-1:0] fm_data_i,
  input  logic                   kw_we_i,
  input  logic [KIDX_W-1:0]      kw_idx_i,
  input  logic [K_COL_BITS-1:0]  kw_data_i,
  input  logic [COL_W-1:0]       rd_col_i,
  input  logic [KIDX_W-1:0]      rd_kidx_i,
  output logic [FM_COL_BITS-1:0] rd_col_o,
  output logic [K_COL_BITS-1:0]  rd_kern_o
);

  logic [FM_COL_BITS-1:0] fm_q [NUM_COLS];
  logic [K_COL_BITS-1:0]  kw_q [KERNEL_SIZE];

  // Storage write; the caller has already range-checked the indices.
  always_ff @(posedge clk_i) begin
    if (fm_we_i) fm_q[fm_col_i] <= fm_data_i;
    if (kw_we_i) kw_q[kw_idx_i] <= kw_data_i;
  end

  assign rd_col_o  = fm_q[rd_col_i];
  assign rd_kern_o = kw_q[rd_kidx_i];

endmodule

// File: rtl/cv3_column_feeder.sv
// Column-stream source: loads kernel columns, then streams the feature map
// one column per cycle on all channels in lockstep.
// Build option: CV3_FEEDER_ZERO_PAD_EN adds PAD zero columns at each edge.
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | writes accepted, waiting for start
// S_LOAD_K | kernel column kidx on kernel_inputs_o
// S_GAP    | one quiet cycle between kernel load and stream
// S_STREAM | issuing columns; hold_i stalls the next issue
// S_FINISH | done_o pulse, back to idle
//
// Outputs are registered, so hold_i sampled in a cycle suppresses the column
// that would have appeared in the following cycle.
module cv3_column_feeder
  import cv3_feeder_pkg::*;
(
  input  logic                                        clk_i,
  input  logic                                        rst_n_i,
  input  logic                                        start_i,
  input  logic                                        hold_i,
  input  logic                                        fm_wr_en_i,
  input  logic [CH_W-1:0]                             fm_wr_ch_i,
  input  logic [COL_W-1:0]                            fm_wr_col_i,
  input  logic [FM_COL_BITS-1:0]                      fm_wr_data_i,
  input  logic                                        kw_wr_en_i,
  input  logic [CH_W-1:0]                             kw_wr_ch_i,
  input  logic [KIDX_W-1:0]                           kw_wr_idx_i,
  input  logic [K_COL_BITS-1:0]                       kw_wr_data_i,
  output logic                                        kernel_load_o,
  output logic [K_COL_BITS*INPUT_CHANNEL_NUMBER-1:0]  kernel_inputs_o,
  output logic                                        col_valid_o,
  output logic [FM_COL_BITS*INPUT_CHANNEL_NUMBER-1:0] input_columns_o,
  output logic                                        busy_o,
  output logic                                        done_o
);

  localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KERNEL_SIZE - 1);
  localparam logic [CNT_W-1:0]  CNT_END   = CNT_W'(N_STREAM);

  state_e                                        state_q, state_d;
  logic [KIDX_W-1:0]                             kidx_q, kidx_d;
  logic [CNT_W-1:0]                              cnt_q, cnt_d;
  logic                                          kernel_load_q, kernel_load_d;
  logic [K_COL_BITS*INPUT_CHANNEL_NUMBER-1:0]    kern_q, kern_d;
  logic                                          col_valid_q, col_valid_d;
  logic [FM_COL_BITS*INPUT_CHANNEL_NUMBER-1:0]   cols_q, cols_d;
  logic                                          busy_q, busy_d;
  logic                                          done_q, done_d;

  logic                                          idle;
  logic                                          fm_we, kw_we;
  logic                                          pad_col;
  logic [COL_W-1:0]                              rd_col;
  logic [KIDX_W-1:0]                             rd_kidx;
  logic [K_COL_BITS*INPUT_CHANNEL_NUMBER-1:0]    kern_rd;
  logic [FM_COL_BITS*INPUT_CHANNEL_NUMBER-1:0]   cols_rd;

  assign idle  = (state_q == S_IDLE);
  assign fm_we = idle && fm_wr_en_i && (fm_wr_col_i < COL_W'(NUM_COLS));
  assign kw_we = idle && kw_wr_en_i && (kw_wr_idx_i < KIDX_W'(KERNEL_SIZE));

  // Kernel index to present next cycle: 0 from idle, else one past current.
  assign rd_kidx = (state_q == S_LOAD_K && kidx_q != KIDX_LAST) ? kidx_q + 1'b1 : '0;

`ifdef CV3_FEEDER_ZERO_PAD_EN
  assign pad_col = (cnt_q < CNT_W'(PAD)) || (cnt_q >= CNT_W'(PAD + NUM_COLS));
  assign rd_col  = pad_col ? '0 : COL_W'(cnt_q - CNT_W'(PAD));
`else
  assign pad_col = 1'b0;
  assign rd_col  = COL_W'(cnt_q);
`endif

  for (genvar g = 0; g < INPUT_CHANNEL_NUMBER; g++) begin : g_ch
    logic [FM_COL_BITS-1:0] fm_rd;
    logic [K_COL_BITS-1:0]  kw_rd;
    logic                   fm_sel, kw_sel;

    assign fm_sel = fm_we && (fm_wr_ch_i == CH_W'(g));
    assign kw_sel = kw_we && (kw_wr_ch_i == CH_W'(g));

    cv3_col_buffer u_buf (
      .clk_i     (clk_i),
      .fm_we_i   (fm_sel),
      .fm_col_i  (fm_wr_col_i),
      .fm_data_i (fm_wr_data_i),
      .kw_we_i   (kw_sel),
      .kw_idx_i  (kw_wr_idx_i),
      .kw_data_i (kw_wr_data_i),
      .rd_col_i  (rd_col),
      .rd_kidx_i (rd_kidx),
      .rd_col_o  (fm_rd),
      .rd_kern_o (kw_rd)
    );

    // A kernel write in the start cycle must reach the first loaded column.
    assign kern_rd[g*K_COL_BITS +: K_COL_BITS] =
      (kw_sel && kw_wr_idx_i == rd_kidx) ? kw_wr_data_i : kw_rd;
    assign cols_rd[g*FM_COL_BITS +: FM_COL_BITS] = pad_col ? '0 : fm_rd;
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d       = state_q;
    kidx_d        = kidx_q;
    cnt_d         = cnt_q;
    kernel_load_d = 1'b0;
    kern_d        = kern_q;
    col_valid_d   = 1'b0;
    cols_d        = cols_q;
    done_d        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        kidx_d = '0;
        cnt_d  = '0;
        if (start_i) begin
          state_d       = S_LOAD_K;
          kernel_load_d = 1'b1;
          kern_d        = kern_rd;
        end
      end
      S_LOAD_K: begin
        cnt_d = '0;
        if (kidx_q == KIDX_LAST) begin
          state_d = S_GAP;
        end else begin
          kidx_d        = rd_kidx;
          kernel_load_d = 1'b1;
          kern_d        = kern_rd;
        end
      end
      S_GAP, S_STREAM: begin
        state_d = S_STREAM;
        if (cnt_q == CNT_END) begin
          state_d = S_FINISH;
          done_d  = 1'b1;
        end else if (!hold_i) begin
          col_valid_d = 1'b1;
          cols_d      = cols_rd;
          cnt_d       = cnt_q + 1'b1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= S_IDLE;
      kidx_q        <= '0;
      cnt_q         <= '0;
      kernel_load_q <= 1'b0;
      kern_q        <= '0;
      col_valid_q   <= 1'b0;
      cols_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      kidx_q        <= kidx_d;
      cnt_q         <= cnt_d;
      kernel_load_q <= kernel_load_d;
      kern_q        <= kern_d;
      col_valid_q   <= col_valid_d;
      cols_q        <= cols_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign kernel_load_o   = kernel_load_q;
  assign kernel_inputs_o = kern_q;
  assign col_valid_o     = col_valid_q;
  assign input_columns_o = cols_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;

endmodule

// File: tb/tb_cv3_column_feeder.sv
// Directed + randomized bench for cv3_column_feeder with a behavioural model.
module tb_cv3_column_feeder;

  localparam int DW = 16, K = 3, CS = 12, CH = 4, NC = 12;
`ifdef CV3_FEEDER_ZERO_PAD_EN
  localparam int PAD = (K - 1) / 2;
`else
  localparam int PAD = 0;
`endif
  localparam int NS  = NC + 2 * PAD;
  localparam int FMB = DW * CS;
  localparam int KB  = DW * K;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, hold = 1'b0;
  logic fm_wr_en = 1'b0, kw_wr_en = 1'b0;
  logic [1:0] fm_wr_ch = '0, kw_wr_ch = '0, kw_wr_idx = '0;
  logic [3:0] fm_wr_col = '0;
  logic [FMB-1:0] fm_wr_data = '0;
  logic [KB-1:0]  kw_wr_data = '0;
  logic kernel_load, col_valid, busy, done;
  logic [KB*CH-1:0]  kernel_inputs;
  logic [FMB*CH-1:0] input_columns;

  logic [FMB-1:0] fm_m [CH][NC];
  logic [KB-1:0]  kw_m [CH][K];

  int n_assert = 0, n_fail = 0;
  string cur = "reset";

  always #5 clk = ~clk;

  cv3_column_feeder dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .start_i         (start),
    .hold_i          (hold),
    .fm_wr_en_i      (fm_wr_en),
    .fm_wr_ch_i      (fm_wr_ch),
    .fm_wr_col_i     (fm_wr_col),
    .fm_wr_data_i    (fm_wr_data),
    .kw_wr_en_i      (kw_wr_en),
    .kw_wr_ch_i      (kw_wr_ch),
    .kw_wr_idx_i     (kw_wr_idx),
    .kw_wr_data_i    (kw_wr_data),
    .kernel_load_o   (kernel_load),
    .kernel_inputs_o (kernel_inputs),
    .col_valid_o     (col_valid),
    .input_columns_o (input_columns),
    .busy_o          (busy),
    .done_o          (done)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [1023:0] obs_v, input logic [1023:0] exp_v);
    n_assert++;
    assert (obs_v === exp_v) else begin
      n_fail++;
      $error("FAIL %s/%s observed=%0h expected=%0h", cur, tag, obs_v, exp_v);
    end
  endtask

  function automatic logic [KB*CH-1:0] exp_kern(input int k);
    logic [KB*CH-1:0] v;
    for (int c = 0; c < CH; c++) v[c*KB +: KB] = kw_m[c][k];
    return v;
  endfunction

  function automatic logic [FMB*CH-1:0] exp_col(input int i);
    logic [FMB*CH-1:0] v;
    v = '0;
    if (i >= PAD && i < PAD + NC)
      for (int c = 0; c < CH; c++) v[c*FMB +: FMB] = fm_m[c][i-PAD];
    return v;
  endfunction

  function automatic logic [FMB-1:0] rnd_col();
    logic [FMB-1:0] v;
    for (int w = 0; w < CS; w++) v[w*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  function automatic logic [KB-1:0] rnd_kcol();
    logic [KB-1:0] v;
    for (int w = 0; w < K; w++) v[w*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  task automatic wr_fm(input int ch, input int col, input logic [FMB-1:0] d);
    fm_wr_en = 1'b1; fm_wr_ch = ch[1:0]; fm_wr_col = col[3:0]; fm_wr_data = d;
    @(negedge clk);
    fm_wr_en = 1'b0;
    if (col < NC) fm_m[ch][col] = d;
  endtask

  task automatic wr_kw(input int ch, input int idx, input logic [KB-1:0] d);
    kw_wr_en = 1'b1; kw_wr_ch = ch[1:0]; kw_wr_idx = idx[1:0]; kw_wr_data = d;
    @(negedge clk);
    kw_wr_en = 1'b0;
    if (idx < K) kw_m[ch][idx] = d;
  endtask

  task automatic fill_pattern();
    logic [FMB-1:0] v;
    logic [KB-1:0] kv;
    for (int ch = 0; ch < CH; ch++) begin
      for (int c = 0; c < NC; c++) begin
        for (int w = 0; w < CS; w++) v[w*DW +: DW] = DW'((ch << 8) | c);
        wr_fm(ch, c, v);
      end
      for (int k = 0; k < K; k++) begin
        for (int w = 0; w < K; w++) kv[w*DW +: DW] = DW'(16'h3C00 + k);
        wr_kw(ch, k, kv);
      end
    end
  endtask

  task automatic fill_random();
    for (int ch = 0; ch < CH; ch++) begin
      for (int c = 0; c < NC; c++) wr_fm(ch, c, rnd_col());
      for (int k = 0; k < K; k++) wr_kw(ch, k, rnd_kcol());
      wr_fm(ch, NC + $urandom_range(0, 3), rnd_col());
      wr_kw(ch, 3, rnd_kcol());
    end
  endtask

  task automatic chk_all_zero();
    chk("kl0", kernel_load, 0);
    chk("ki0", kernel_inputs, 0);
    chk("cv0", col_valid, 0);
    chk("ic0", input_columns, 0);
    chk("busy0", busy, 0);
    chk("done0", done, 0);
  endtask

  // mode: 0 plain, 1 two hold cycles before column 5, 2 random hold,
  //       3 intrusive start/writes while busy, 4 reset while column 7 shown
  task automatic run_seq(input string tag, input int mode, input bit same_wr);
    int cyc, next_col, n_hold, hp5;
    bit held_prev, fin;
    logic [FMB-1:0] nf;
    logic [KB-1:0] nk;
    cur = tag;
    chk("idle_busy", busy, 0);
    start = 1'b1;
    nf = rnd_col();
    nk = rnd_kcol();
    if (same_wr) begin
      fm_wr_en = 1'b1; fm_wr_ch = 2'd2; fm_wr_col = 4'd0; fm_wr_data = nf;
      kw_wr_en = 1'b1; kw_wr_ch = 2'd1; kw_wr_idx = 2'd0; kw_wr_data = nk;
    end
    @(negedge clk);
    start = 1'b0; fm_wr_en = 1'b0; kw_wr_en = 1'b0;
    if (same_wr) begin fm_m[2][0] = nf; kw_m[1][0] = nk; end
    cyc = 1;
    for (int k = 0; k < K; k++) begin
      chk("load_kl", kernel_load, 1);
      chk("load_ki", kernel_inputs, exp_kern(k));
      chk("load_cv", col_valid, 0);
      chk("load_busy", busy, 1);
      hold = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (mode == 3 && k == 1) begin
        fm_wr_en = 1'b1; fm_wr_ch = 2'd0; fm_wr_col = 4'd0; fm_wr_data = rnd_col();
        kw_wr_en = 1'b1; kw_wr_ch = 2'd0; kw_wr_idx = 2'd2; kw_wr_data = rnd_kcol();
      end
      @(negedge clk);
      fm_wr_en = 1'b0; kw_wr_en = 1'b0;
      cyc++;
    end
    chk("gap_kl", kernel_load, 0);
    chk("gap_cv", col_valid, 0);
    chk("gap_busy", busy, 1);
    chk("gap_done", done, 0);
    hold = 1'b0;
    @(negedge clk);
    cyc++;
    next_col = 0; n_hold = 0; hp5 = 0; held_prev = 1'b0; fin = 1'b0;
    for (int guard = 0; guard < 300 && !fin; guard++) begin
      if (next_col == NS) begin
        chk("done", done, 1);
        chk("fin_cv", col_valid, 0);
        chk("fin_busy", busy, 1);
        chk("latency", cyc, K + 2 + NS + n_hold);
        fin = 1'b1;
      end else begin
        chk("cv", col_valid, !held_prev);
        if (!held_prev) begin
          chk("col", input_columns, exp_col(next_col));
          next_col++;
        end else if (next_col > 0) begin
          chk("held_col", input_columns, exp_col(next_col - 1));
        end
        chk("str_done", done, 0);
        if (mode == 4 && next_col == 8) begin
          rst_n = 1'b0;
          #1;
          chk_all_zero();
          @(negedge clk);
          rst_n = 1'b1;
          @(negedge clk);
          chk("post_rst_busy", busy, 0);
          return;
        end
        hold = 1'b0;
        if (next_col < NS) begin
          if (mode == 1 && next_col == 5 && hp5 < 2) begin hold = 1'b1; hp5++; end
          if (mode == 2) hold = ($urandom_range(0, 3) == 0);
        end
        if (mode == 3 && next_col == 3) start = 1'b1;
        held_prev = hold;
        n_hold += int'(hold);
        @(negedge clk);
        cyc++;
        start = 1'b0;
      end
    end
    if (!fin) chk("timeout_done", 0, 1);
    hold = 1'b0;
    @(negedge clk);
    chk("end_busy", busy, 0);
    chk("end_done", done, 0);
    chk("end_cv", col_valid, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_all_zero();
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero();

    fill_pattern();
    run_seq("basic", 0, 1'b0);
    run_seq("hold5", 1, 1'b0);
    run_seq("intrude", 3, 1'b0);
    run_seq("after_intrude", 0, 1'b0);

    fill_random();
    for (int i = 0; i < 3; i++) run_seq("rand_hold", 2, 1'b0);
    run_seq("same_cycle_wr", 0, 1'b1);

    run_seq("reset_mid", 4, 1'b0);
    fill_random();
    run_seq("after_reset", 0, 1'b0);
    run_seq("after_reset_hold", 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
